// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction-fetch request sequencer.
// No logic; enum encoding and the stale-response depth live here.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_MAX_STALE = 2;

endpackage

// File: rtl/rv_fetch_req_add.sv
// Combinational adder with carry-in, used for the fetch word-address increment.
// Zero latency; no flow control.
module add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b + {{(WIDTH-1){1'b0}}, i_carry};

endmodule

// File: rtl/rv_fetch_req.sv
// Fetch request sequencer: one live word read at a time, stale reads drained and dropped after a redirect.
// Request comb from IDLE (same cycle as eligibility), held until accepted; pushes comb from i_bus_rvalid.
module rv_fetch_req
    import rv_fetch_pkg::*;
#(
    parameter int                          IADDR_SPACE_BITS = 16,
    parameter int                          WIDTH            = 16,
    parameter logic [IADDR_SPACE_BITS-2:0] RESET_PC         = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic [IADDR_SPACE_BITS-2:0]   i_flush_pc,
    output logic                          o_bus_req,
    output logic [IADDR_SPACE_BITS-3:0]   o_bus_addr,
    input  logic                          i_bus_ready,
    input  logic                          i_bus_rvalid,
    input  logic [2*WIDTH-1:0]            i_bus_rdata,
    input  logic                          i_buf_full,
    output logic                          o_push_single,
    output logic                          o_push_double,
    output logic [WIDTH-1:0]              o_data_lo,
    output logic [WIDTH-1:0]              o_data_hi,
    output logic                          o_buf_clear,
    output logic [IADDR_SPACE_BITS-2:0]   o_buf_pc
);

    localparam int AW = IADDR_SPACE_BITS - 2;
    localparam int PW = IADDR_SPACE_BITS - 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [AW-1:0]   r_fetch_addr;
    logic            r_misalign;
    logic            r_live;
    logic [1:0]      r_stale;
    logic            r_buf_clear;
    logic [PW-1:0]   r_buf_pc;

    logic            w_start;
    logic            w_bus_req;
    logic            w_accept;
    logic            w_live_rsp;
    logic            w_drop;
    logic            w_staled;
    logic [1:0]      w_stale_nxt;
    logic [AW-1:0]   w_addr_inc;

    add #(.WIDTH(AW)) u_add (
        .i_a     (r_fetch_addr),
        .i_b     ({{(AW-1){1'b0}}, 1'b1}),
        .i_carry (1'b0),
        .o_sum   (w_addr_inc)
    );

    assign w_start    = (r_state == IDLE) & !i_flush & !r_buf_clear & !i_buf_full &
                        !r_live & (r_stale < 2'(FETCH_MAX_STALE));
    assign w_bus_req  = (r_state == REQ) | w_start;
    assign w_accept   = w_bus_req & i_bus_ready;
    assign w_live_rsp = i_bus_rvalid & (r_stale == 2'd0) & r_live & !i_flush & !r_buf_clear;

    // A response at the flush cycle with nothing stale is the live one: it cancels its own staling.
    assign w_drop      = i_bus_rvalid & ((r_stale != 2'd0) | (i_flush & r_live));
    assign w_staled    = i_flush & (r_live | w_accept);
    assign w_stale_nxt = r_stale + 2'(w_staled) - 2'(w_drop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = i_bus_ready ? WAIT : REQ;
            REQ:     if (i_bus_ready) w_state_nxt = WAIT;
            WAIT:    if (w_live_rsp) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fetch_addr <= RESET_PC[PW-1:1];
            r_misalign   <= RESET_PC[0];
            r_live       <= 1'b0;
            r_stale      <= 2'd0;
            r_buf_clear  <= 1'b1;
            r_buf_pc     <= RESET_PC;
        end else begin
            r_stale <= w_stale_nxt;
            if (i_flush) begin
                r_buf_clear  <= 1'b1;
                r_buf_pc     <= i_flush_pc;
                r_fetch_addr <= i_flush_pc[PW-1:1];
                r_misalign   <= i_flush_pc[0];
                r_live       <= 1'b0;
            end else begin
                r_buf_clear <= 1'b0;
                if (w_accept) begin
                    r_fetch_addr <= w_addr_inc;
                    r_live       <= 1'b1;
                end else if (w_live_rsp) begin
                    r_live <= 1'b0;
                end
                if (w_live_rsp) r_misalign <= 1'b0;
            end
        end
    end

    assign o_bus_req     = w_bus_req;
    assign o_bus_addr    = r_fetch_addr;
    assign o_push_single = w_live_rsp & r_misalign;
    assign o_push_double = w_live_rsp & !r_misalign;
    assign o_data_lo     = i_bus_rdata[WIDTH-1:0];
    assign o_data_hi     = i_bus_rdata[2*WIDTH-1:WIDTH];
    assign o_buf_clear   = r_buf_clear;
    assign o_buf_pc      = r_buf_pc;

endmodule

// File: tb/tb_rv_fetch_req.sv
// Bench for rv_fetch_req: directed scenarios followed by a randomized run against a stream/epoch model.
module tb_rv_fetch_req;

    localparam int IAB = 16;
    localparam int W   = 16;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_flush;
    logic [14:0]   i_flush_pc;
    logic          o_bus_req;
    logic [13:0]   o_bus_addr;
    logic          i_bus_ready;
    logic          i_bus_rvalid;
    logic [31:0]   i_bus_rdata;
    logic          i_buf_full;
    logic          o_push_single;
    logic          o_push_double;
    logic [15:0]   o_data_lo;
    logic [15:0]   o_data_hi;
    logic          o_buf_clear;
    logic [14:0]   o_buf_pc;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rv_fetch_req #(.IADDR_SPACE_BITS(IAB), .WIDTH(W), .RESET_PC(15'h100)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .i_bus_ready(i_bus_ready),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .i_buf_full(i_buf_full),
        .o_push_single(o_push_single), .o_push_double(o_push_double),
        .o_data_lo(o_data_lo), .o_data_hi(o_data_hi),
        .o_buf_clear(o_buf_clear), .o_buf_pc(o_buf_pc)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_flush = 1'b0; i_flush_pc = '0; i_bus_ready = 1'b0;
        i_bus_rvalid = 1'b0; i_bus_rdata = '0; i_buf_full = 1'b0;
        nxt(); nxt(); smp();
        vecs++;
        if ({o_buf_clear, o_bus_req, o_push_single, o_push_double, o_bus_addr, o_buf_pc} !==
            {4'b1000, 14'h80, 15'h100}) begin
            $display("FAIL reset_vals: got clr=%b req=%b ps=%b pd=%b addr=%h pc=%h want 1 0 0 0 0080 0100",
                     o_buf_clear, o_bus_req, o_push_single, o_push_double, o_bus_addr, o_buf_pc);
            errs++;
        end
        nxt(); i_reset_n = 1'b1; i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_buf_clear, o_bus_req} !== 2'b10) begin
            $display("FAIL release_cycle: got clr=%b req=%b want 1 0", o_buf_clear, o_bus_req); errs++;
        end
        nxt(); smp();
        vecs++;
        if ({o_buf_clear, o_bus_req, o_bus_addr} !== {2'b01, 14'h80}) begin
            $display("FAIL first_req: got clr=%b req=%b addr=%h want 0 1 0080", o_buf_clear, o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hAAAA_5555; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi, o_data_lo} !== {2'b01, 32'hAAAA_5555}) begin
            $display("FAIL first_push: got ps=%b pd=%b hi=%h lo=%h want 0 1 aaaa 5555",
                     o_push_single, o_push_double, o_data_hi, o_data_lo); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h81}) begin
            $display("FAIL next_addr: got req=%b addr=%h want 1 0081", o_bus_req, o_bus_addr); errs++;
        end
    endtask

    task automatic test_flush_misaligned();
        logic [31:0] d;
        d = $urandom;
        nxt(); i_flush = 1'b1; i_flush_pc = 15'h103;
        nxt(); i_flush = 1'b0; smp();
        vecs++;
        if ({o_buf_clear, o_buf_pc, o_bus_req} !== {1'b1, 15'h103, 1'b0}) begin
            $display("FAIL flush_clear: got clr=%b pc=%h req=%b want 1 0103 0", o_buf_clear, o_buf_pc, o_bus_req); errs++;
        end
        nxt(); i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_buf_clear, o_bus_req, o_bus_addr} !== {2'b01, 14'h81}) begin
            $display("FAIL flush_req: got clr=%b req=%b addr=%h want 0 1 0081", o_buf_clear, o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_ABCD; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi} !== {2'b10, 16'h1234}) begin
            $display("FAIL misalign_single: got ps=%b pd=%b hi=%h want 1 0 1234", o_push_single, o_push_double, o_data_hi); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0; i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h82}) begin
            $display("FAIL after_single_req: got req=%b addr=%h want 1 0082", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = d; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi, o_data_lo} !== {2'b01, d}) begin
            $display("FAIL after_single_double: got ps=%b pd=%b data=%h%h want 0 1 %h",
                     o_push_single, o_push_double, o_data_hi, o_data_lo, d); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0;
    endtask

    task automatic test_flush_stale();
        logic [31:0] d;
        d = $urandom;
        i_flush = 1'b1; i_flush_pc = 15'h080;
        nxt(); i_flush = 1'b0;
        nxt(); i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h40}) begin
            $display("FAIL stale_req40: got req=%b addr=%h want 1 0040", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_flush = 1'b1; i_flush_pc = 15'h200;
        nxt(); i_flush = 1'b0; smp();
        vecs++;
        if ({o_buf_clear, o_push_single, o_push_double} !== 3'b100) begin
            $display("FAIL stale_clear_cycle: got clr=%b ps=%b pd=%b want 1 0 0", o_buf_clear, o_push_single, o_push_double); errs++;
        end
        nxt(); i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h100}) begin
            $display("FAIL stale_newreq: got req=%b addr=%h want 1 0100", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = ~d; smp();
        vecs++;
        if ({o_push_single, o_push_double} !== 2'b00) begin
            $display("FAIL stale_drop: got ps=%b pd=%b want 0 0", o_push_single, o_push_double); errs++;
        end
        nxt(); i_bus_rdata = d; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi, o_data_lo} !== {2'b01, d}) begin
            $display("FAIL stale_newpush: got ps=%b pd=%b data=%h%h want 0 1 %h",
                     o_push_single, o_push_double, o_data_hi, o_data_lo, d); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0;
    endtask

    task automatic test_double_stale();
        logic [31:0] d;
        d = $urandom;
        i_bus_ready = 1'b1;
        nxt(); i_bus_ready = 1'b0; i_flush = 1'b1; i_flush_pc = 15'h300;
        nxt(); i_flush = 1'b0;
        nxt(); i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h180}) begin
            $display("FAIL dstale_req180: got req=%b addr=%h want 1 0180", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_flush = 1'b1; i_flush_pc = 15'h400;
        nxt(); i_flush = 1'b0;
        nxt(); smp();
        vecs++;
        if ({o_buf_clear, o_bus_req} !== 2'b00) begin
            $display("FAIL dstale_block: got clr=%b req=%b want 0 0", o_buf_clear, o_bus_req); errs++;
        end
        nxt(); i_bus_rvalid = 1'b1; i_bus_rdata = $urandom; smp();
        vecs++;
        if ({o_bus_req, o_push_single, o_push_double} !== 3'b000) begin
            $display("FAIL dstale_drop1: got req=%b ps=%b pd=%b want 0 0 0", o_bus_req, o_push_single, o_push_double); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h200}) begin
            $display("FAIL dstale_resume: got req=%b addr=%h want 1 0200", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_rvalid = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_push_single, o_push_double} !== 3'b100) begin
            $display("FAIL dstale_drop2: got req=%b ps=%b pd=%b want 1 0 0", o_bus_req, o_push_single, o_push_double); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0; i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h200}) begin
            $display("FAIL dstale_held: got req=%b addr=%h want 1 0200", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = d; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi, o_data_lo} !== {2'b01, d}) begin
            $display("FAIL dstale_push: got ps=%b pd=%b data=%h%h want 0 1 %h",
                     o_push_single, o_push_double, o_data_hi, o_data_lo, d); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0;
    endtask

    task automatic test_buf_full();
        logic [31:0] d;
        d = $urandom;
        i_buf_full = 1'b1; i_bus_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp();
            vecs++;
            if (o_bus_req !== 1'b0) begin
                $display("FAIL full_block[%0d]: got req=%b want 0", c, o_bus_req); errs++;
            end
            nxt();
        end
        i_buf_full = 1'b0; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h201}) begin
            $display("FAIL full_release: got req=%b addr=%h want 1 0201", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = d; smp();
        vecs++;
        if ({o_push_single, o_push_double, o_data_hi, o_data_lo} !== {2'b01, d}) begin
            $display("FAIL full_push: got ps=%b pd=%b data=%h%h want 0 1 %h",
                     o_push_single, o_push_double, o_data_hi, o_data_lo, d); errs++;
        end
        nxt(); i_bus_rvalid = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        i_flush = 1'b1; i_flush_pc = 15'h7FFE;
        nxt(); i_flush = 1'b0;
        nxt(); i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h3FFF}) begin
            $display("FAIL wrap_top: got req=%b addr=%h want 1 3fff", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = $urandom;
        nxt(); i_bus_rvalid = 1'b0; i_bus_ready = 1'b1; smp();
        vecs++;
        if ({o_bus_req, o_bus_addr} !== {1'b1, 14'h0000}) begin
            $display("FAIL wrap_zero: got req=%b addr=%h want 1 0000", o_bus_req, o_bus_addr); errs++;
        end
        nxt(); i_bus_ready = 1'b0; smp();
        #1 i_reset_n = 1'b0; i_bus_rvalid = 1'b1;
        #1;
        vecs++;
        if ({o_buf_clear, o_bus_req, o_push_single, o_push_double, o_bus_addr, o_buf_pc} !==
            {4'b1000, 14'h80, 15'h100}) begin
            $display("FAIL async_reset: got clr=%b req=%b ps=%b pd=%b addr=%h pc=%h want 1 0 0 0 0080 0100",
                     o_buf_clear, o_bus_req, o_push_single, o_push_double, o_bus_addr, o_buf_pc);
            errs++;
        end
        nxt(); i_bus_rvalid = 1'b0;
    endtask

    // Model: each accepted read is tagged with the stream epoch it was issued in; a
    // flush starts a new epoch, and only responses of the current epoch reach the buffer.
    task automatic test_random();
        int          cur;
        int          cyc;
        int          q_ep[$];
        int          q_due[$];
        bit          q_mis[$];
        logic [13:0] exp_addr;
        bit          exp_mis;
        bit          prev_flush;
        logic [14:0] exp_pc;
        bit          pend;
        bit          cur_out;
        bit          exp_req;
        bit          live;
        cur = 0; cyc = 0; exp_addr = 14'h80; exp_mis = 1'b0; prev_flush = 1'b1;
        exp_pc = 15'h100; pend = 1'b0;
        i_reset_n = 1'b0; i_flush = 1'b0; i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_buf_full = 1'b0;
        nxt(); nxt(); i_reset_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            i_flush      = ($urandom_range(15) == 0);
            i_flush_pc   = 15'($urandom);
            i_buf_full   = ($urandom_range(3) == 0);
            i_bus_ready  = ($urandom_range(1) == 1);
            i_bus_rvalid = (q_ep.size() > 0) && (q_due[0] <= cyc) && ($urandom_range(1) == 1);
            i_bus_rdata  = $urandom;
            smp();
            cur_out = 1'b0;
            foreach (q_ep[j]) if (q_ep[j] == cur) cur_out = 1'b1;
            exp_req = !prev_flush && !cur_out && (q_ep.size() < 2) && (pend || (!i_flush && !i_buf_full));
            live    = i_bus_rvalid && !i_flush && !prev_flush && (q_ep[0] == cur);
            vecs++;
            if (o_buf_clear !== prev_flush) begin
                $display("FAIL rnd_clear@%0d: got %b want %b", cyc, o_buf_clear, prev_flush); errs++;
            end
            if (prev_flush) begin
                vecs++;
                if (o_buf_pc !== exp_pc) begin
                    $display("FAIL rnd_bufpc@%0d: got %h want %h", cyc, o_buf_pc, exp_pc); errs++;
                end
            end
            vecs++;
            if (o_bus_req !== exp_req) begin
                $display("FAIL rnd_req@%0d: got %b want %b", cyc, o_bus_req, exp_req); errs++;
            end
            if (exp_req) begin
                vecs++;
                if (o_bus_addr !== exp_addr) begin
                    $display("FAIL rnd_addr@%0d: got %h want %h", cyc, o_bus_addr, exp_addr); errs++;
                end
            end
            vecs++;
            if ({o_push_single, o_push_double} !== {live && q_mis[0], live && !q_mis[0]}) begin
                $display("FAIL rnd_push@%0d: got ps=%b pd=%b want %b %b", cyc, o_push_single, o_push_double,
                         live && q_mis[0], live && !q_mis[0]); errs++;
            end
            if (live) begin
                vecs++;
                if ({o_data_hi, o_data_lo} !== i_bus_rdata) begin
                    $display("FAIL rnd_data@%0d: got %h%h want %h", cyc, o_data_hi, o_data_lo, i_bus_rdata); errs++;
                end
            end
            if (i_bus_rvalid) begin
                void'(q_ep.pop_front()); void'(q_due.pop_front()); void'(q_mis.pop_front());
            end
            if (exp_req && i_bus_ready) begin
                q_ep.push_back(cur); q_due.push_back(cyc + 1); q_mis.push_back(exp_mis);
                exp_addr = exp_addr + 14'd1;
                exp_mis  = 1'b0;
            end
            if (i_flush) begin
                cur++;
                exp_addr = i_flush_pc[14:1];
                exp_mis  = i_flush_pc[0];
                exp_pc   = i_flush_pc;
            end
            pend       = exp_req && !i_bus_ready && !i_flush;
            prev_flush = i_flush;
            nxt();
            cyc++;
        end
        i_flush = 1'b0; i_bus_rvalid = 1'b0; i_bus_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flush_misaligned();
        test_flush_stale();
        test_double_stale();
        test_buf_full();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
